// File: rtl/mul_issue_ctrl.sv
// Operand FIFO plus one-at-a-time launcher for the 32x32 signed multiplier; optional LATENCY_STAT_EN adds lat_min/lat_max.
// Latency: launch two edges after the first push into an empty FIFO; result registered on the mul_valid edge.
// Backpressure: in_ready = !full; no launch while a captured result is still waiting for out_ready.

module mul_issue_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = 1;
   localparam logic [AW:0]   CNT_ONE   = 1;
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (count == CNT_DEPTH);
   assign empty    = (count == '0);
endmodule

module mul_issue_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 40,
   parameter int LAT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_mlier,
   input  logic [31:0]      in_mcand,
   output logic             mul_start,
   output logic [31:0]      mul_mlier,
   output logic [31:0]      mul_mcand,
   input  logic [63:0]      mul_prodt,
   input  logic             mul_valid,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_prodt,
   output logic [LAT_W-1:0] out_latency,
   output logic             timeout_err,
   output logic             busy
`ifdef LATENCY_STAT_EN
   ,
   output logic [LAT_W-1:0] lat_min,
   output logic [LAT_W-1:0] lat_max
`endif
);
   typedef struct packed {
      logic [31:0] mlier;
      logic [31:0] mcand;
   } op_t;

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   localparam logic [LAT_W-1:0] LAT_ONE     = 1;
   localparam logic [LAT_W-1:0] LAT_MAX     = '1;
   localparam logic [LAT_W-1:0] TIMEOUT_CNT = LAT_W'(TIMEOUT);

   state_t           state_q;
   state_t           state_d;
   op_t              push_op;
   op_t              head_op;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic             slot_free;
   logic             launch;
   logic             capture;
   logic             abort;
   logic [LAT_W-1:0] lat_cnt;

   assign push_op.mlier = in_mlier;
   assign push_op.mcand = in_mcand;
   assign in_ready      = !fifo_full;
   assign fifo_push     = in_valid && in_ready;

   mul_issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(op_t))
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifo_push),
      .push_dat (push_op),
      .pop      (launch),
      .head_dat (head_op),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // A held result may be handed off on the same edge that launches the next op.
   assign slot_free = !out_valid || out_ready;

   always_ff @(posedge clock) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && slot_free) begin
               launch  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (mul_valid) begin
               capture = 1'b1;
               state_d = GAP;
            end else if (lat_cnt == TIMEOUT_CNT) begin
               abort   = 1'b1;
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mul_start   <= 1'b0;
         mul_mlier   <= '0;
         mul_mcand   <= '0;
         lat_cnt     <= '0;
         out_valid   <= 1'b0;
         out_prodt   <= '0;
         out_latency <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (launch) begin
            mul_start <= 1'b1;
            mul_mlier <= head_op.mlier;
            mul_mcand <= head_op.mcand;
            lat_cnt   <= LAT_ONE;
         end else if (capture || abort) begin
            mul_start <= 1'b0;
         end else if (state_q == RUN && lat_cnt != LAT_MAX) begin
            lat_cnt <= lat_cnt + LAT_ONE;
         end

         if (capture) begin
            out_prodt   <= mul_prodt;
            out_latency <= lat_cnt;
         end

         if (capture)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;

         if (abort)
            timeout_err <= 1'b1;
      end
   end

`ifdef LATENCY_STAT_EN
   // Timed-out ops never reach capture, so they stay out of the statistics.
   always_ff @(posedge clock) begin
      if (reset) begin
         lat_min <= '1;
         lat_max <= '0;
      end else if (capture) begin
         if (lat_cnt < lat_min)
            lat_min <= lat_cnt;
         if (lat_cnt > lat_max)
            lat_max <= lat_cnt;
      end
   end
`endif

   assign busy = !fifo_empty || (state_q != IDLE) || out_valid;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural multiplier model with programmable latency,
// table of operand/product vectors, and a result scoreboard checked on each output handshake.
module tb_mul_issue_ctrl;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 40;
   localparam int LAT_W   = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_mlier = '0;
   logic [31:0]      in_mcand = '0;
   logic             mul_start;
   logic [31:0]      mul_mlier;
   logic [31:0]      mul_mcand;
   logic [63:0]      mul_prodt;
   logic             mul_valid;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [63:0]      out_prodt;
   logic [LAT_W-1:0] out_latency;
   logic             timeout_err;
   logic             busy;
`ifdef LATENCY_STAT_EN
   logic [LAT_W-1:0] lat_min;
   logic [LAT_W-1:0] lat_max;
`endif

   mul_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .LAT_W(LAT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mlier    (in_mlier),
      .in_mcand    (in_mcand),
      .mul_start   (mul_start),
      .mul_mlier   (mul_mlier),
      .mul_mcand   (mul_mcand),
      .mul_prodt   (mul_prodt),
      .mul_valid   (mul_valid),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_prodt   (out_prodt),
      .out_latency (out_latency),
      .timeout_err (timeout_err),
      .busy        (busy)
`ifdef LATENCY_STAT_EN
      ,
      .lat_min     (lat_min),
      .lat_max     (lat_max)
`endif
   );

   always #5 clock = ~clock;

   // Multiplier model: answers in the mdl_lat-th cycle of a start pulse; ops before answer_from get no answer.
   int   m_cnt = 0;
   int   n_ops = 0;
   int   answer_from = 0;
   int   mdl_lat = 3;
   logic stray = 1'b0;

   always @(posedge clock) begin
      if (mul_start === 1'b1) begin
         m_cnt <= m_cnt + 1;
      end else begin
         if (m_cnt != 0)
            n_ops <= n_ops + 1;
         m_cnt <= 0;
      end
   end

   assign mul_valid = stray || ((mul_start === 1'b1) && (m_cnt + 1 == mdl_lat) && (n_ops >= answer_from));
   assign mul_prodt = $signed({{32{mul_mlier[31]}}, mul_mlier}) * $signed({{32{mul_mcand[31]}}, mul_mcand});

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] prodt;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] mlier;
      logic [31:0] mcand;
      logic [63:0] prodt;
      int          lat;
   } vec_t;

   exp_t sb[$];
   int   n_out = 0;
   int   cyc = 0;
   int   last_rise = 0;
   int   last_interval = 0;
   int   hi_cnt = 0;
   int   hi_hist[$];
   logic prev_start = 1'b0;

   // Sampled after the stimulus for the coming edge is in place, so valid & ready here is the handshake.
   always @(negedge clock) begin
      #2;
      cyc++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_out++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got result %h, required no result", out_prodt);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_prodt", out_prodt, e.prodt);
            check("out_latency", 64'(out_latency), 64'(e.lat));
         end
      end
      if (mul_start === 1'b1) begin
         if (!prev_start) begin
            last_interval = cyc - last_rise;
            last_rise     = cyc;
         end
         hi_cnt++;
      end else if (prev_start) begin
         hi_hist.push_back(hi_cnt);
         hi_cnt = 0;
      end
      prev_start = (mul_start === 1'b1);
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                       input int lat, input bit expect_out);
      int n = 0;
      in_valid = 1'b1;
      in_mlier = a;
      in_mcand = b;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_wait: in_ready %b after 200 cycles, required 1", in_ready);
      end else if (expect_out) begin
         exp_t e;
         e.prodt = p;
         e.lat   = lat;
         sb.push_back(e);
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clock);
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_idle: busy %b after 2000 cycles, required 0", busy);
      end
   endtask

   vec_t vec[11];
   int   seq_a[4] = '{0, 5, 6, 7};
   int   stat_lat[3] = '{5, 20, 12};

   initial begin
      int n;
      int bad;
      int out0;
      vec[0]  = '{32'h7fffffff, 32'h7fffffff, 64'h3fffffff00000001, 33};
      vec[1]  = '{32'hffffffff, 32'hffffffff, 64'h0000000000000001, 3};
      vec[2]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 3};
      vec[3]  = '{32'h00000001, 32'h80000000, 64'hffffffff80000000, 3};
      vec[4]  = '{32'h00000000, 32'h7fffffff, 64'h0000000000000000, 3};
      vec[5]  = '{32'h00000003, 32'hfffffffd, 64'hfffffffffffffff7, 1};
      vec[6]  = '{32'h12345678, 32'h00000010, 64'h0000000123456780, 40};
      vec[7]  = '{32'h80000000, 32'h7fffffff, 64'hc000000080000000, 2};
      vec[8]  = '{32'h00000002, 32'h00000003, 64'h0000000000000006, 3};
      vec[9]  = '{32'h00000005, 32'h00000007, 64'h0000000000000023, 0};
      vec[10] = '{32'hfffffffe, 32'h00000003, 64'hfffffffffffffffa, 3};

      repeat (2) @(negedge clock);
      check("rst_mul_start", 64'(mul_start), 64'd0);
      check("rst_mul_mlier", 64'(mul_mlier), 64'd0);
      check("rst_mul_mcand", 64'(mul_mcand), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_prodt", out_prodt, 64'd0);
      check("rst_out_latency", 64'(out_latency), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef LATENCY_STAT_EN
      check("rst_lat_min", 64'(lat_min), 64'hff);
      check("rst_lat_max", 64'(lat_max), 64'd0);
`endif
      reset = 1'b0;

      // Single ops at latencies 33, 1, TIMEOUT and 2; start must stay high exactly the latency.
      foreach (seq_a[k]) begin
         vec_t v;
         v       = vec[seq_a[k]];
         mdl_lat = v.lat;
         push(v.mlier, v.mcand, v.prodt, v.lat, 1'b1);
         wait_idle();
         check($sformatf("start_len_vec%0d", seq_a[k]), 64'(hi_hist[$]), 64'(v.lat));
      end
      check("single_drained", 64'(sb.size()), 64'd0);

      // Hold a result, fill the FIFO behind it, then release.
      mdl_lat   = 3;
      out_ready = 1'b0;
      push(vec[8].mlier, vec[8].mcand, vec[8].prodt, vec[8].lat, 1'b1);
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("blocker_valid", 64'(out_valid), 64'd1);
      for (int i = 1; i <= 4; i++) begin
         push(vec[i].mlier, vec[i].mcand, vec[i].prodt, vec[i].lat, 1'b1);
         check($sformatf("in_ready_after_push%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      end
      bad = 0;
      repeat (6) begin
         @(negedge clock);
         if (mul_start !== 1'b0 || out_valid !== 1'b1 || out_prodt !== vec[8].prodt || out_latency !== 8'd3)
            bad++;
      end
      check("hold_stable", 64'(bad), 64'd0);
      out_ready = 1'b1;
      @(negedge clock);
      check("launch_on_accept", 64'(mul_start), 64'd1);
      check("accept_clears_valid", 64'(out_valid), 64'd0);
      check("in_ready_after_pop", 64'(in_ready), 64'd1);
      wait_idle();
      check("issue_interval", 64'(last_interval), 64'(3 + 2));
      check("burst_drained", 64'(sb.size()), 64'd0);

      // Unanswered op times out; the op queued behind it completes.
      out0        = n_out;
      answer_from = n_ops + 1;
      push(vec[9].mlier, vec[9].mcand, vec[9].prodt, vec[9].lat, 1'b0);
      push(vec[10].mlier, vec[10].mcand, vec[10].prodt, vec[10].lat, 1'b1);
      n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("timeout_set", 64'(timeout_err), 64'd1);
      check("timeout_no_valid", 64'(out_valid), 64'd0);
      check("timeout_no_output", 64'(n_out - out0), 64'd0);
      wait_idle();
      check("timeout_start_len", 64'(hi_hist[hi_hist.size() - 2]), 64'(TIMEOUT));
      check("after_timeout_len", 64'(hi_hist[$]), 64'd3);
      check("timeout_sticky", 64'(timeout_err), 64'd1);
      check("after_timeout_output", 64'(n_out - out0), 64'd1);
      check("timeout_drained", 64'(sb.size()), 64'd0);

      // Reset in the 10th RUN cycle with a second op still queued.
      mdl_lat = 33;
      push(vec[0].mlier, vec[0].mcand, vec[0].prodt, vec[0].lat, 1'b1);
      push(vec[5].mlier, vec[5].mcand, vec[5].prodt, vec[5].lat, 1'b1);
      check("run_before_reset", 64'(mul_start), 64'd1);
      repeat (9) @(negedge clock);
      sb.delete();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midrst_mul_start", 64'(mul_start), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_timeout_err", 64'(timeout_err), 64'd0);
      stray = 1'b1;
      @(negedge clock);
      stray = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if (out_valid !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0)
            bad++;
      end
      check("stray_valid_ignored", 64'(bad), 64'd0);

      // Variable latency after reset: 5, 20, 12.
      foreach (stat_lat[k]) begin
         mdl_lat = stat_lat[k];
         push(vec[k + 1].mlier, vec[k + 1].mcand, vec[k + 1].prodt, stat_lat[k], 1'b1);
         wait_idle();
      end
      check("stat_drained", 64'(sb.size()), 64'd0);
`ifdef LATENCY_STAT_EN
      check("lat_min", 64'(lat_min), 64'd5);
      check("lat_max", 64'(lat_max), 64'd20);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Front-end sequencer that feeds the 32x32 signed multiplier (fixed- or variable-latency variant). It buffers operand pairs from a valid/ready producer in a small FIFO and launches one multiplication at a time. It drives start and the operands, waits for the multiplier's valid, and presents the 64-bit product with its measured latency on a valid/ready output. It also enforces a completion timeout.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, minimum 2
TIMEOUT, 40, maximum cycles from launch to mul_valid before the op is aborted
LAT_W, 8, width of the latency counter and the out_latency field

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept; equals !full
in_mlier  input  32  signed multiplier operand
in_mcand  input  32  signed multiplicand operand
mul_start  output  1  start to the multiplier
mul_mlier  output  32  operand to the multiplier
mul_mcand  output  32  operand to the multiplier
mul_prodt  input  64  product from the multiplier
mul_valid  input  1  product-valid pulse from the multiplier
out_valid  output  1  result held
out_ready  input  1  consumer accepts the result
out_prodt  output  64  captured product
out_latency  output  LAT_W  cycles from launch to mul_valid, inclusive
timeout_err  output  1  sticky; set on any timeout
busy  output  1  high when FIFO is non-empty, FSM is not IDLE, or out_valid is high

Behaviour:
- Reset is synchronous: at the first clock edge with reset high, the FIFO is emptied and the FSM goes to IDLE. All outputs reset to 0: mul_start, mul_mlier, mul_mcand, out_valid, out_prodt, out_latency, timeout_err and busy. in_ready becomes 1.
- Reset mid-operation: the in-flight op is discarded, and mul_start is low from the edge on which reset is applied.
- FIFO push happens on in_valid & in_ready. When full, in_ready=0 and the offered pair is held by the producer, not dropped. Push and pop may occur in the same cycle; in that case the count is unchanged.
- FSM has three states: IDLE, RUN, GAP.
- IDLE -> RUN when the FIFO is non-empty and the output slot is free. The slot is free when out_valid=0, or when out_valid & out_ready in the same cycle.
  - On this transition the head is popped into mul_mlier/mul_mcand, mul_start goes to 1, and lat_cnt is set to 1.
- RUN: mul_start stays 1, and operands are stable for the entire op. lat_cnt increments by 1 each cycle and saturates at its maximum.
  - If mul_valid=1: out_prodt <= mul_prodt, out_latency <= lat_cnt, out_valid <= 1, mul_start <= 0, next state GAP.
  - Else if lat_cnt == TIMEOUT: timeout_err <= 1, mul_start <= 0, op discarded with no output, next state GAP.
- GAP: mul_start=0 for exactly one cycle, so the multiplier sees a fresh rising edge on the next launch. Then -> IDLE.
  - Minimum issue interval is therefore latency + 2 cycles.
- A mul_valid seen in IDLE or GAP is ignored: no capture and no error.
- Output holds out_prodt and out_latency stable while out_valid & !out_ready. out_valid clears on out_ready the cycle after acceptance unless a new capture happens on the same edge.
- The product is passed through unmodified; the block does no arithmetic on operands or product.
- timeout_err clears only on reset.

Optional Feature:
LATENCY_STAT_EN
- Defined: adds two outputs, lat_min and lat_max, both LAT_W wide.
  - Reset values: lat_min = all ones, lat_max = 0.
  - Both are updated on each successful capture. Timed-out ops are excluded.
- Undefined: neither port nor the supporting registers exist; all other behaviour is identical.

Test Plan:
- Multiplier model with latency 33; push 7fffffff*7fffffff, out_ready=1 -> out_prodt=3fffffff00000001, out_latency=33, mul_start high for exactly 33 cycles.
- Push four pairs back-to-back with DEPTH=4: ffffffff*ffffffff, 80000000*80000000, 00000001*80000000, 00000000*7fffffff.
  -> in_ready drops after the 4th push.
  -> outputs in order: 0000000000000001, 4000000000000000, ffffffff80000000, 0000000000000000.
  -> one GAP cycle between consecutive start pulses.
- Hold out_ready=0 after the first result -> no second launch; out_prodt stable. Raise out_ready -> next launch occurs on the same edge as acceptance.
- Model never asserts mul_valid, TIMEOUT=40 -> mul_start drops after 40 cycles; timeout_err=1 and stays sticky; no out_valid; the next queued op completes normally.
- Assert reset during RUN at cycle 10 -> next edge: mul_start=0, FIFO empty, in_ready=1, out_valid=0; a later mul_valid is ignored.
- With LATENCY_STAT_EN, variable-latency model giving 5, 20 and 12 -> lat_min=5, lat_max=20.
